// File: rtl/rps_match_controller.sv
// Best-of-N stone-paper-scissors match sequencer: move handshakes, round judging, scoring.
// Optional result history shift register enabled by defining RPS_HISTORY_EN.
module rps_match_controller #(
  parameter int unsigned WIN_TARGET = 3,
  parameter int unsigned MAX_ROUNDS = 15,
  parameter int unsigned SCORE_W    = 3,
  parameter int unsigned TIMEOUT    = 200,
  parameter int unsigned TO_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         p1_move,
  input  logic               p1_valid,
  output logic               p1_ready,
  input  logic [1:0]         p2_move,
  input  logic               p2_valid,
  output logic               p2_ready,
  output logic [1:0]         round_result,
  output logic               result_valid,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [7:0]         round_cnt,
  output logic               match_done,
  output logic [1:0]         match_winner,
  output logic               busy,
  output logic [2:0]         state_dbg,
  output logic [7:0]         history
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_COLLECT = 3'b001,
    ST_JUDGE   = 3'b010,
    ST_UPDATE  = 3'b011,
    ST_DONE    = 3'b100
  } state_t;

  localparam logic [SCORE_W-1:0] WIN_LIMIT   = SCORE_W'(WIN_TARGET);
  localparam logic [7:0]         ROUND_LIMIT = 8'(MAX_ROUNDS);
  localparam logic [TO_W-1:0]    TO_LIMIT    = TO_W'(TIMEOUT);
  localparam bit                 TO_EN       = (TIMEOUT != 0);

  state_t             state_r, state_s;
  logic [1:0]         p1_move_r, p1_move_s, p2_move_r, p2_move_s;
  logic               p1_lock_r, p1_lock_s, p2_lock_r, p2_lock_s;
  logic [TO_W-1:0]    timer_r, timer_s;
  logic [1:0]         round_result_r, round_result_s;
  logic               result_valid_r, result_valid_s;
  logic [SCORE_W-1:0] p1_score_r, p1_score_s, p2_score_r, p2_score_s;
  logic [7:0]         round_cnt_r, round_cnt_s;
  logic               p1_ready_r, p1_ready_s, p2_ready_r, p2_ready_s;
  logic               match_done_r, match_done_s;
  logic [1:0]         match_winner_r, match_winner_s;
  logic               busy_r, busy_s;
  logic               clear_s;
`ifdef RPS_HISTORY_EN
  logic [7:0]         history_r, history_s;
`endif

  function automatic logic [1:0] judge_round(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    if (a == 2'b11 || b == 2'b11) begin
      r = 2'b11;
    end else if (a == b) begin
      r = 2'b00;
    end else if ((a == 2'b00 && b == 2'b10) || (a == 2'b01 && b == 2'b00) ||
                 (a == 2'b10 && b == 2'b01)) begin
      r = 2'b01;
    end else begin
      r = 2'b10;
    end
    return r;
  endfunction

  // Next-state, datapath and registered-output next values
  always_comb begin
    state_s        = state_r;
    p1_move_s      = p1_move_r;
    p2_move_s      = p2_move_r;
    p1_lock_s      = p1_lock_r;
    p2_lock_s      = p2_lock_r;
    timer_s        = timer_r;
    round_result_s = round_result_r;
    result_valid_s = 1'b0;
    p1_score_s     = p1_score_r;
    p2_score_s     = p2_score_r;
    round_cnt_s    = round_cnt_r;
    clear_s        = start && (state_r == ST_IDLE || state_r == ST_DONE);

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (clear_s) begin
          state_s        = ST_COLLECT;
          p1_score_s     = '0;
          p2_score_s     = '0;
          round_cnt_s    = 8'd0;
          round_result_s = 2'b00;
          p1_lock_s      = 1'b0;
          p2_lock_s      = 1'b0;
          timer_s        = '0;
        end else begin
          state_s = state_r;
        end
      end
      ST_COLLECT: begin
        if (p1_valid && p1_ready_r) begin
          p1_move_s = p1_move;
          p1_lock_s = 1'b1;
        end else begin
          p1_lock_s = p1_lock_r;
        end
        if (p2_valid && p2_ready_r) begin
          p2_move_s = p2_move;
          p2_lock_s = 1'b1;
        end else begin
          p2_lock_s = p2_lock_r;
        end
        // A late handshake wins over a forfeit landing on the same edge
        if (p1_lock_s && p2_lock_s) begin
          state_s = ST_JUDGE;
        end else if (p1_lock_r != p2_lock_r) begin
          if (TO_EN && timer_r == TO_LIMIT) begin
            round_result_s = p1_lock_r ? 2'b01 : 2'b10;
            result_valid_s = 1'b1;
            state_s        = ST_UPDATE;
          end else if (TO_EN) begin
            timer_s = timer_r + TO_W'(1);
          end else begin
            timer_s = timer_r;
          end
        end else begin
          timer_s = timer_r;
        end
      end
      ST_JUDGE: begin
        round_result_s = judge_round(p1_move_r, p2_move_r);
        result_valid_s = 1'b1;
        state_s        = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (p1_score_r == WIN_LIMIT || p2_score_r == WIN_LIMIT || round_cnt_r == ROUND_LIMIT) begin
          state_s = ST_DONE;
        end else begin
          state_s   = ST_COLLECT;
          p1_lock_s = 1'b0;
          p2_lock_s = 1'b0;
          timer_s   = '0;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Counters move on the same edge the result is registered
    if (result_valid_s) begin
      case (round_result_s)
        2'b01: begin
          p1_score_s  = p1_score_r + SCORE_W'(1);
          round_cnt_s = round_cnt_r + 8'd1;
        end
        2'b10: begin
          p2_score_s  = p2_score_r + SCORE_W'(1);
          round_cnt_s = round_cnt_r + 8'd1;
        end
        2'b00: begin
          round_cnt_s = round_cnt_r + 8'd1;
        end
        default: begin
          round_cnt_s = round_cnt_r;
        end
      endcase
    end else begin
      round_cnt_s = round_cnt_s;
    end

`ifdef RPS_HISTORY_EN
    if (clear_s) begin
      history_s = 8'h00;
    end else if (result_valid_s) begin
      history_s = {history_r[5:0], round_result_s};
    end else begin
      history_s = history_r;
    end
`endif

    p1_ready_s   = (state_s == ST_COLLECT) && !p1_lock_s;
    p2_ready_s   = (state_s == ST_COLLECT) && !p2_lock_s;
    busy_s       = (state_s == ST_COLLECT) || (state_s == ST_JUDGE) || (state_s == ST_UPDATE);
    match_done_s = (state_s == ST_DONE);
    if (state_s == ST_DONE) begin
      if (p1_score_r > p2_score_r) begin
        match_winner_s = 2'b01;
      end else if (p1_score_r < p2_score_r) begin
        match_winner_s = 2'b10;
      end else begin
        match_winner_s = 2'b00;
      end
    end else begin
      match_winner_s = 2'b00;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      p1_move_r      <= 2'b00;
      p2_move_r      <= 2'b00;
      p1_lock_r      <= 1'b0;
      p2_lock_r      <= 1'b0;
      timer_r        <= '0;
      round_result_r <= 2'b00;
      result_valid_r <= 1'b0;
      p1_score_r     <= '0;
      p2_score_r     <= '0;
      round_cnt_r    <= 8'd0;
      p1_ready_r     <= 1'b0;
      p2_ready_r     <= 1'b0;
      match_done_r   <= 1'b0;
      match_winner_r <= 2'b00;
      busy_r         <= 1'b0;
`ifdef RPS_HISTORY_EN
      history_r      <= 8'h00;
`endif
    end else begin
      state_r        <= state_s;
      p1_move_r      <= p1_move_s;
      p2_move_r      <= p2_move_s;
      p1_lock_r      <= p1_lock_s;
      p2_lock_r      <= p2_lock_s;
      timer_r        <= timer_s;
      round_result_r <= round_result_s;
      result_valid_r <= result_valid_s;
      p1_score_r     <= p1_score_s;
      p2_score_r     <= p2_score_s;
      round_cnt_r    <= round_cnt_s;
      p1_ready_r     <= p1_ready_s;
      p2_ready_r     <= p2_ready_s;
      match_done_r   <= match_done_s;
      match_winner_r <= match_winner_s;
      busy_r         <= busy_s;
`ifdef RPS_HISTORY_EN
      history_r      <= history_s;
`endif
    end
  end

  assign p1_ready     = p1_ready_r;
  assign p2_ready     = p2_ready_r;
  assign round_result = round_result_r;
  assign result_valid = result_valid_r;
  assign p1_score     = p1_score_r;
  assign p2_score     = p2_score_r;
  assign round_cnt    = round_cnt_r;
  assign match_done   = match_done_r;
  assign match_winner = match_winner_r;
  assign busy         = busy_r;
  assign state_dbg    = state_r;
`ifdef RPS_HISTORY_EN
  assign history      = history_r;
`else
  assign history      = 8'h00;
`endif

endmodule

// File: tb/tb_rps_match_controller.sv
// Directed bench for rps_match_controller: round-level scoreboard model plus literal pins.
module tb_rps_match_controller;
  localparam int WIN = 3, MAXR = 15, TO = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, p1_valid, p2_valid;
  logic [1:0] p1_move, p2_move;
  logic p1_ready, p2_ready, result_valid, match_done, busy;
  logic [1:0] round_result, match_winner;
  logic [2:0] p1_score, p2_score, state_dbg;
  logic [7:0] round_cnt, history;

  logic z_start, z_p1_valid, z_p2_valid;
  logic [1:0] z_p1_move, z_p2_move;
  logic z_p1_ready, z_p2_ready, z_result_valid, z_match_done, z_busy;
  logic [1:0] z_round_result, z_match_winner;
  logic [2:0] z_p1_score, z_p2_score, z_state_dbg;
  logic [7:0] z_round_cnt, z_history;

  rps_match_controller #(.WIN_TARGET(WIN), .MAX_ROUNDS(MAXR), .SCORE_W(3), .TIMEOUT(TO), .TO_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .p1_move(p1_move), .p1_valid(p1_valid), .p1_ready(p1_ready),
    .p2_move(p2_move), .p2_valid(p2_valid), .p2_ready(p2_ready),
    .round_result(round_result), .result_valid(result_valid),
    .p1_score(p1_score), .p2_score(p2_score), .round_cnt(round_cnt),
    .match_done(match_done), .match_winner(match_winner), .busy(busy),
    .state_dbg(state_dbg), .history(history));

  rps_match_controller #(.WIN_TARGET(WIN), .MAX_ROUNDS(MAXR), .SCORE_W(3), .TIMEOUT(0), .TO_W(8)) u_dut_noto (
    .clk(clk), .rst(rst), .start(z_start),
    .p1_move(z_p1_move), .p1_valid(z_p1_valid), .p1_ready(z_p1_ready),
    .p2_move(z_p2_move), .p2_valid(z_p2_valid), .p2_ready(z_p2_ready),
    .round_result(z_round_result), .result_valid(z_result_valid),
    .p1_score(z_p1_score), .p2_score(z_p2_score), .round_cnt(z_round_cnt),
    .match_done(z_match_done), .match_winner(z_match_winner), .busy(z_busy),
    .state_dbg(z_state_dbg), .history(z_history));

  int vectors = 0, miscompares = 0, cyc = 0, z_pulses = 0;

  typedef struct { logic [1:0] res; int p1; int p2; int cnt; int at; } exp_t;
  exp_t q[$];
  int m_p1 = 0, m_p2 = 0, m_cnt = 0;
  int s_p1 = 0, s_p2 = 0, s_cnt = 0;
  logic [7:0] s_hist = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (z_result_valid) z_pulses <= z_pulses + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Game rule: a beats b when b is the move two steps after a (mod 3)
  function automatic logic [1:0] rule(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'd3 || b == 2'd3) return 2'b11;
    if (a == b) return 2'b00;
    if (int'(b) == (int'(a) + 2) % 3) return 2'b01;
    return 2'b10;
  endfunction

  task automatic expect_round(input logic [1:0] res, input int at);
    exp_t e;
    case (res)
      2'b01: begin m_p1++; m_cnt++; end
      2'b10: begin m_p2++; m_cnt++; end
      2'b00: m_cnt++;
      default: ;
    endcase
    e.res = res; e.p1 = m_p1; e.p2 = m_p2; e.cnt = m_cnt; e.at = at;
    q.push_back(e);
  endtask

  always @(negedge clk) begin : cmp
    exp_t e;
    if (result_valid) begin
      if (q.size() == 0) check("spurious_result_valid", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        check("result_cycle", cyc, e.at);
        check("round_result", round_result, e.res);
        s_p1 = e.p1; s_p2 = e.p2; s_cnt = e.cnt;
        s_hist = {s_hist[5:0], e.res};
      end
    end else if (q.size() > 0 && q[0].at <= cyc) begin
      check("result_valid_missing", result_valid, 1'b1);
      void'(q.pop_front());
    end
    check("p1_score", p1_score, s_p1);
    check("p2_score", p2_score, s_p2);
    check("round_cnt", round_cnt, s_cnt);
`ifdef RPS_HISTORY_EN
    check("history", history, s_hist);
`else
    check("history", history, 8'h00);
`endif
    check("match_done_vs_state", match_done, state_dbg == 3'b100);
    check("busy_vs_state", busy, state_dbg inside {3'b001, 3'b010, 3'b011});
    if (state_dbg != 3'b001) begin
      check("p1_ready_outside_collect", p1_ready, 1'b0);
      check("p2_ready_outside_collect", p2_ready, 1'b0);
    end
    if (match_done)
      check("match_winner", match_winner, (s_p1 > s_p2) ? 2'b01 : (s_p1 < s_p2) ? 2'b10 : 2'b00);
  end

  task automatic clear_model();
    m_p1 = 0; m_p2 = 0; m_cnt = 0; s_p1 = 0; s_p2 = 0; s_cnt = 0; s_hist = 8'h00;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    clear_model();
  endtask

  task automatic send_both(input logic [1:0] m1, input logic [1:0] m2, output int hs);
    bit got = 0;
    hs = 0;
    @(posedge clk); #1;
    p1_move = m1; p2_move = m2; p1_valid = 1'b1; p2_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (p1_ready && p2_ready) begin got = 1; hs = cyc; end
    end
    if (got) expect_round(rule(m1, m2), hs + 2);
    else check("handshake_timeout", 32'd0, 32'd1);
    @(posedge clk); #1 p1_valid = 1'b0; p2_valid = 1'b0;
  endtask

  task automatic wait_result(input int bound);
    for (int i = 0; i < bound && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      check("result_wait_timeout", 32'd0, 32'd1);
      q.delete();
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : stim
    int hs;
    rst = 1'b1; start = 1'b0; p1_valid = 1'b0; p2_valid = 1'b0; p1_move = 2'b00; p2_move = 2'b00;
    z_start = 1'b0; z_p1_valid = 1'b0; z_p2_valid = 1'b0; z_p1_move = 2'b00; z_p2_move = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", state_dbg, 3'b000);
    check("rst_ready", {p1_ready, p2_ready}, 2'b00);
    check("rst_outputs", {round_result, result_valid, match_done, match_winner, busy}, 7'd0);
    check("rst_history", history, 8'h00);
    @(posedge clk); #1 rst = 1'b0;

    // TIMEOUT=0 instance: a lone lock never forfeits
    @(posedge clk); #1 z_start = 1'b1;
    @(posedge clk); #1 z_start = 1'b0;
    @(posedge clk); #1 z_p1_valid = 1'b1;
    @(posedge clk); #1 z_p1_valid = 1'b0;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check("noto_state", z_state_dbg, 3'b001);
    check("noto_readys", {z_p1_ready, z_p2_ready}, 2'b01);
    check("noto_no_result", z_pulses, 32'd0);

    do_start();
    send_both(2'b00, 2'b10, hs);
    wait_result(10);
    check("t1_result", round_result, 2'b01);
    check("t1_p1_score", p1_score, 3'd1);
    check("t1_round_cnt", round_cnt, 8'd1);

    send_both(2'b11, 2'b00, hs);
    wait_result(10);
    @(negedge clk);
    check("t3_result", round_result, 2'b11);
    check("t3_readys_replay", {p1_ready, p2_ready}, 2'b11);
    check("t3_round_cnt", round_cnt, 8'd1);

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_ignored_busy", state_dbg, 3'b001);

    // Staggered arrival: p2 paper first, p1 scissors three cycles later
    @(posedge clk); #1 p2_move = 2'b01; p2_valid = 1'b1;
    @(negedge clk); check("stagger_p2_ready", p2_ready, 1'b1);
    @(posedge clk); #1 p2_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 p1_move = 2'b10; p1_valid = 1'b1;
    @(negedge clk);
    check("stagger_readys", {p1_ready, p2_ready}, 2'b10);
    check("stagger_no_forfeit", state_dbg, 3'b001);
    expect_round(rule(2'b10, 2'b01), cyc + 2);
    @(posedge clk); #1 p1_valid = 1'b0;
    wait_result(10);
    check("stagger_p1_score", p1_score, 3'd2);

    send_both(2'b01, 2'b00, hs);
    wait_result(10);
    @(negedge clk);
    check("t2_state", state_dbg, 3'b100);
    check("t2_done_winner", {match_done, match_winner}, 3'b101);
    check("t2_scores", {p1_score, p2_score}, 6'b011_000);
    @(posedge clk); #1 p1_valid = 1'b1; p2_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("t2_readys_low", {p1_ready, p2_ready}, 2'b00);
    check("t2_still_done", state_dbg, 3'b100);
    @(posedge clk); #1 p1_valid = 1'b0; p2_valid = 1'b0;

    // Forfeit: p1 locks, p2 silent
    do_start();
    @(posedge clk); #1 p1_move = 2'b00; p1_valid = 1'b1;
    @(negedge clk);
    check("forfeit_p1_ready", p1_ready, 1'b1);
    expect_round(2'b01, cyc + TO + 2);
    @(posedge clk); #1 p1_valid = 1'b0;
    wait_result(TO + 20);
    check("forfeit_result", round_result, 2'b01);
    check("forfeit_p1_score", p1_score, 3'd1);

    send_both(2'b00, 2'b10, hs);
    wait_result(10);
    send_both(2'b00, 2'b10, hs);
    wait_result(10);
    do_start();
    for (int i = 0; i < MAXR; i++) begin
      send_both(2'b00, 2'b00, hs);
      wait_result(10);
    end
    @(negedge clk);
    check("t5_state", state_dbg, 3'b100);
    check("t5_round_cnt", round_cnt, 8'd15);
    check("t5_winner", match_winner, 2'b00);
    do_start();
    @(negedge clk);
    check("t5_restart_state", state_dbg, 3'b001);
    check("t5_restart_counts", {p1_score, p2_score, round_cnt}, 14'd0);

    send_both(2'b00, 2'b10, hs);
    wait_result(10);
    send_both(2'b00, 2'b01, hs);
    wait_result(10);
    send_both(2'b01, 2'b01, hs);
    wait_result(10);
`ifdef RPS_HISTORY_EN
    check("history_literal", history, 8'h18);
`else
    check("history_literal", history, 8'h00);
`endif

    // Reset while judging
    send_both(2'b10, 2'b01, hs);
    check("pre_rst_judge", state_dbg, 3'b010);
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1 clear_model();
    @(negedge clk);
    check("rst_judge_state", state_dbg, 3'b000);
    check("rst_judge_outputs", {result_valid, round_result, p1_score, p2_score, round_cnt}, 17'd0);
    check("rst_judge_flags", {p1_ready, p2_ready, busy, match_done, history}, 12'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
